// File: rtl/ultrasonic_scan_scheduler_if.sv
// ultrasonic_scan_scheduler_if: sensor, trigger and result-read signals of the scan scheduler
interface ultrasonic_scan_scheduler_if;
  logic        enable;
  logic [3:0]  sensor_mask;
  logic [3:0]  echo;
  logic [3:0]  trigger;
  logic [1:0]  rd_sel;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [1:0]  rd_status;
  logic        busy;
  logic [1:0]  cur_sensor;
  logic        done;
  modport master (
    output enable, sensor_mask, echo, rd_sel, rd_ack,
    input  trigger, rd_data, rd_status, busy, cur_sensor, done
  );
  modport slave (
    input  enable, sensor_mask, echo, rd_sel, rd_ack,
    output trigger, rd_data, rd_status, busy, cur_sensor, done
  );
endinterface

// File: rtl/ultrasonic_scan_scheduler.sv
// ultrasonic_scan_scheduler: round-robin trigger/echo-width measurement over four ultrasonic sensors
module ultrasonic_scan_scheduler #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
  parameter int unsigned GAP_CYCLES     = 3_000_000
) (
  input logic clk,
  input logic reset_l,
  ultrasonic_scan_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cur_q, cur_d, nxt;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  trig_q, trig_d;
  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  valid_q, valid_d, to_q, to_d;
  logic [31:0] dist_q [4];
  logic [31:0] dist_d [4];
  logic        wr, wr_to, echo_s;
  logic [31:0] wr_data;
  always_comb begin
    nxt = cur_q;
    for (int i = 3; i >= 0; i--)
      if (bus.sensor_mask[cur_q + 2'(i + 1)]) nxt = cur_q + 2'(i + 1);
  end
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    wr      = 1'b0;
    wr_to   = 1'b0;
    wr_data = '0;
    echo_s  = sync2_q[cur_q];
    case (state_q)
      IDLE:
        if (bus.enable && |bus.sensor_mask) begin
          state_d = TRIG;
          cur_d   = nxt;
          cnt_d   = '0;
        end
      TRIG:
        if (cnt_q == TRIG_CYCLES - 1) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1;
      WAIT_RISE:
        // the rise cycle itself is the first cycle of echo width
        if (echo_s) begin
          state_d = MEASURE;
          cnt_d   = 32'd1;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d = GAP;
          cnt_d   = '0;
          wr      = 1'b1;
          wr_to   = 1'b1;
        end else cnt_d = cnt_q + 1;
      MEASURE:
        if (!echo_s) begin
          state_d = GAP;
          cnt_d   = '0;
          wr      = 1'b1;
          wr_data = cnt_q;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d = GAP;
          cnt_d   = '0;
          wr      = 1'b1;
          wr_to   = 1'b1;
          wr_data = TIMEOUT_CYCLES;
        end else cnt_d = cnt_q + 1;
      GAP:
        if (cnt_q == GAP_CYCLES - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1;
      default: state_d = IDLE;
    endcase
    if (!bus.enable && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      wr      = 1'b0;
    end
  end
  always_comb begin
    trig_d  = (state_d == TRIG) ? 4'b0001 << cur_d : '0;
    valid_d = valid_q;
    to_d    = to_q;
    dist_d  = dist_q;
    if (bus.rd_ack) valid_d[bus.rd_sel] = 1'b0;
    // a same-cycle write overrides the acknowledge
    if (wr) begin
      valid_d[cur_q] = 1'b1;
      to_d[cur_q]    = wr_to;
      dist_d[cur_q]  = wr_data;
    end
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state_q <= IDLE;
      cur_q   <= 2'd3;
      cnt_q   <= '0;
      trig_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      valid_q <= '0;
      to_q    <= '0;
      dist_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      sync1_q <= bus.echo;
      sync2_q <= sync1_q;
      valid_q <= valid_d;
      to_q    <= to_d;
      dist_q  <= dist_d;
    end
  assign bus.trigger    = trig_q;
  assign bus.rd_data    = dist_q[bus.rd_sel];
  assign bus.rd_status  = {to_q[bus.rd_sel], valid_q[bus.rd_sel]};
  assign bus.busy       = state_q != IDLE;
  assign bus.cur_sensor = cur_q;
  assign bus.done       = wr;
endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// tb_ultrasonic_scan_scheduler: table-driven ping vectors with a result scoreboard plus abort/ack/reset sequences
module tb_ultrasonic_scan_scheduler;
  localparam int PULSE = 0, NEVER = 1, STUCK = 2;
  typedef struct { int mask, mode, delay, len, s, d, st; } rec_t;
  typedef struct packed { logic [1:0] s; logic [31:0] d; logic [1:0] st; } exp_t;
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int checks = 0, errors = 0, cyc = 0, done_cyc = 0;
  rec_t tbl [10];
  exp_t sbq [$];
  logic [31:0] m_d [4];
  logic [1:0] m_st [4];
  ultrasonic_scan_scheduler_if bus();
  ultrasonic_scan_scheduler #(.TRIG_CYCLES(4), .TIMEOUT_CYCLES(100), .GAP_CYCLES(10)) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", n, a, x);
    end
  endtask
  task automatic expire(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got no event within bound, required event", n);
  endtask
  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.trigger != 0) begin ok = 1'b1; break; end
    end
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
  endtask
  task automatic wait_trig_low(output int w, output int last_hi);
    w = 0;
    last_hi = cyc;
    while (bus.trigger != 0 && w < 20) begin
      w++;
      last_hi = cyc;
      @(negedge clk);
    end
  endtask
  task automatic check_slots(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.rd_sel = 2'(i);
      #1;
      chk({tag, "_data"}, bus.rd_data, m_d[i]);
      chk({tag, "_status"}, 32'(bus.rd_status), 32'(m_st[i]));
    end
  endtask
  task automatic run_rec(input rec_t r, input bit first);
    bit ok;
    int w, last_hi;
    exp_t e;
    bus.sensor_mask = 4'(r.mask);
    wait_trig(ok);
    if (!ok) begin expire("trigger_start"); return; end
    chk("trig_onehot", 32'(bus.trigger), 32'(4'b0001 << r.s));
    if (!first) chk("trig_gap", 32'(cyc - done_cyc), 32'd12);
    if (r.mode == STUCK) bus.echo = 4'(1 << r.s);
    wait_trig_low(w, last_hi);
    chk("trig_width", 32'(w), 32'd4);
    sbq.push_back('{2'(r.s), 32'(r.d), 2'(r.st)});
    if (r.mode == NEVER) bus.echo = ~4'(1 << r.s);
    if (r.mode == PULSE) begin
      repeat (r.delay) @(negedge clk);
      bus.echo = 4'(1 << r.s);
      repeat (r.len) @(negedge clk);
      bus.echo = '0;
    end
    wait_done(ok);
    e = sbq.pop_front();
    if (!ok) begin expire("done"); bus.echo = '0; return; end
    done_cyc = cyc;
    if (r.mode != PULSE) chk("timeout_latency", 32'(cyc - last_hi), 32'd100);
    bus.echo = '0;
    bus.rd_sel = e.s;
    chk("cur_sensor", 32'(bus.cur_sensor), 32'(e.s));
    @(negedge clk);
    chk("rd_data", bus.rd_data, e.d);
    chk("rd_status", 32'(bus.rd_status), 32'(e.st));
    chk("done_once", 32'(bus.done), 32'd0);
    m_d[e.s] = e.d;
    m_st[e.s] = e.st;
  endtask
  initial begin
    bit ok;
    int w, last_hi, seen;
    bus.enable = 1'b0;
    bus.sensor_mask = '0;
    bus.echo = '0;
    bus.rd_sel = '0;
    bus.rd_ack = 1'b0;
    tbl[0] = '{'b0001, PULSE, 5, 37, 0, 37, 1};
    tbl[1] = '{'b1011, PULSE, 3, 10, 1, 10, 1};
    tbl[2] = '{'b1011, PULSE, 0, 1, 3, 1, 1};
    tbl[3] = '{'b1011, PULSE, 2, 55, 0, 55, 1};
    tbl[4] = '{'b1011, PULSE, 7, 20, 1, 20, 1};
    tbl[5] = '{'b1011, PULSE, 1, 99, 3, 99, 1};
    tbl[6] = '{'b0100, NEVER, 0, 0, 2, 0, 3};
    tbl[7] = '{'b0100, STUCK, 0, 0, 2, 100, 3};
    tbl[8] = '{'b0010, PULSE, 4, 100, 1, 100, 3};
    tbl[9] = '{'b1000, PULSE, 90, 2, 3, 2, 1};
    for (int i = 0; i < 4; i++) begin m_d[i] = '0; m_st[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_trigger", 32'(bus.trigger), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_cur", 32'(bus.cur_sensor), 32'd3);
    check_slots("reset");
    @(negedge clk);
    reset_l = 1'b1;
    bus.sensor_mask = 4'b1111;
    repeat (5) @(negedge clk);
    chk("idle_disabled_busy", 32'(bus.busy), 32'd0);
    bus.sensor_mask = '0;
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_nomask_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 10; i++) run_rec(tbl[i], i == 0);
    check_slots("table");
    bus.sensor_mask = 4'b0001;
    wait_trig(ok);
    if (!ok) expire("ack_trigger");
    else begin
      wait_trig_low(w, last_hi);
      repeat (2) @(negedge clk);
      bus.echo = 4'b0001;
      repeat (5) @(negedge clk);
      bus.echo = '0;
      wait_done(ok);
      if (!ok) expire("ack_done");
      else begin
        bus.rd_sel = 2'd0;
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        chk("ack_same_status", 32'(bus.rd_status), 32'd1);
        chk("ack_same_data", bus.rd_data, 32'd5);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        chk("ack_lone_status", 32'(bus.rd_status), 32'd0);
        m_d[0] = 32'd5;
        m_st[0] = 2'd0;
      end
    end
    wait_trig(ok);
    if (!ok) expire("abort_trigger_start");
    else begin
      wait_trig_low(w, last_hi);
      bus.echo = 4'b0001;
      repeat (10) @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      chk("abort_trigger", 32'(bus.trigger), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      bus.echo = '0;
      seen = 0;
      repeat (120) begin
        @(negedge clk);
        if (bus.done) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      check_slots("abort");
    end
    bus.enable = 1'b1;
    wait_trig(ok);
    if (!ok) expire("reset_trigger_start");
    else begin
      #2 reset_l = 1'b0;
      #1;
      chk("rst_trigger_drop", 32'(bus.trigger), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_cur", 32'(bus.cur_sensor), 32'd3);
      for (int i = 0; i < 4; i++) begin m_d[i] = '0; m_st[i] = '0; end
      check_slots("rst");
      @(negedge clk);
      bus.enable = 1'b0;
      reset_l = 1'b1;
      @(negedge clk);
      chk("rst_idle_busy", 32'(bus.busy), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
